// File: rtl/adbg_spr_arbiter.sv
// adbg_spr_arbiter: round-robin arbiter steering OR1K SPR debug accesses onto a per-core SPR bus array.
// Build macro ADBG_SPR_TIMEOUT_EN bounds each strobe to TIMEOUT_CYCLES cycles with an error response.
module adbg_spr_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int NB_CORES       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       cpu_clk_i,
  input  logic                       trstn_i,
  input  logic [NB_REQ-1:0]          req_valid_i,
  output logic [NB_REQ-1:0]          req_ready_o,
  input  logic [NB_REQ-1:0][3:0]     req_core_i,
  input  logic [NB_REQ-1:0][15:0]    req_addr_i,
  input  logic [NB_REQ-1:0][31:0]    req_wdata_i,
  input  logic [NB_REQ-1:0]          req_we_i,
  output logic [NB_REQ-1:0]          resp_valid_o,
  output logic [31:0]                resp_rdata_o,
  output logic                       resp_err_o,
  output logic [NB_CORES-1:0][15:0]  cpu_addr_o,
  output logic [NB_CORES-1:0][31:0]  cpu_data_o,
  output logic [NB_CORES-1:0]        cpu_we_o,
  output logic [NB_CORES-1:0]        cpu_stb_o,
  input  logic [NB_CORES-1:0][31:0]  cpu_data_i,
  input  logic [NB_CORES-1:0]        cpu_ack_i
);

  localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                      state_r;
  state_e                      state_nxt_s;
  logic [PTR_W-1:0]            rr_ptr_r;
  logic [PTR_W-1:0]            grant_r;
  logic [PTR_W-1:0]            pick_idx_s;
  logic                        pick_vld_s;
  logic [3:0]                  sel_core_s;
  logic [15:0]                 sel_addr_s;
  logic [31:0]                 sel_wdata_s;
  logic                        sel_we_s;
  logic                        core_bad_s;
  logic [NB_CORES-1:0]         core_oh_s;
  logic                        we_r;
  logic                        ack_sel_s;
  logic [31:0]                 ack_data_s;
  logic                        accept_s;
  logic                        done_ok_s;
  logic                        done_err_s;
  logic                        timeout_s;
  logic [NB_REQ-1:0]           resp_valid_r;
  logic [31:0]                 resp_rdata_r;
  logic                        resp_err_r;
  logic [NB_CORES-1:0][15:0]   cpu_addr_r;
  logic [NB_CORES-1:0][31:0]   cpu_data_r;
  logic [NB_CORES-1:0]         cpu_we_r;
  logic [NB_CORES-1:0]         cpu_stb_r;

  function automatic logic [NB_REQ-1:0] req_onehot(input logic [PTR_W-1:0] idx);
    logic [NB_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      oh[i] = (idx == PTR_W'(i));
    end
    return oh;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NB_REQ - 1)) begin
      return '0;
    end else begin
      return idx + PTR_W'(1);
    end
  endfunction

  // Round-robin pick: descending scan so the lowest offset from rr_ptr_r wins.
  always_comb begin
    int idx_v;
    pick_vld_s = 1'b0;
    pick_idx_s = '0;
    idx_v      = 0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      idx_v = (int'(rr_ptr_r) + k) % NB_REQ;
      if (req_valid_i[idx_v]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = PTR_W'(idx_v);
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  assign sel_core_s  = req_core_i[pick_idx_s];
  assign sel_addr_s  = req_addr_i[pick_idx_s];
  assign sel_wdata_s = req_wdata_i[pick_idx_s];
  assign sel_we_s    = req_we_i[pick_idx_s];
  assign core_bad_s  = ({1'b0, sel_core_s} >= 5'(NB_CORES));

  // Target-core decode and return-path select; the strobe register doubles as the core select.
  always_comb begin
    core_oh_s  = '0;
    ack_data_s = 32'd0;
    for (int c = 0; c < NB_CORES; c++) begin
      core_oh_s[c] = (sel_core_s == 4'(c));
      if (cpu_stb_r[c]) begin
        ack_data_s = ack_data_s | cpu_data_i[c];
      end else begin
        ack_data_s = ack_data_s;
      end
    end
  end

  assign ack_sel_s = |(cpu_ack_i & cpu_stb_r);

`ifdef ADBG_SPR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_r;

  // Counts completed strobe cycles of the current access.
  always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tmo_cnt_r <= '0;
    end else if (accept_s) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ACCESS) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign timeout_s = (state_r == ACCESS) && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and acceptance handshake; an ack on the final timeout cycle wins.
  always_comb begin
    state_nxt_s = state_r;
    req_ready_o = '0;
    accept_s    = 1'b0;
    done_ok_s   = 1'b0;
    done_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          req_ready_o[pick_idx_s] = 1'b1;
          accept_s                = 1'b1;
          if (core_bad_s) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = ACCESS;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (ack_sel_s) begin
          done_ok_s   = 1'b1;
          state_nxt_s = RESP;
        end else if (timeout_s) begin
          done_err_s  = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Grant bookkeeping and round-robin pointer.
  always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      grant_r  <= '0;
      we_r     <= 1'b0;
      rr_ptr_r <= '0;
    end else if (accept_s) begin
      grant_r  <= pick_idx_s;
      we_r     <= sel_we_s;
      rr_ptr_r <= rr_ptr_r;
    end else if (state_r == RESP) begin
      grant_r  <= grant_r;
      we_r     <= we_r;
      rr_ptr_r <= ptr_next(grant_r);
    end else begin
      grant_r  <= grant_r;
      we_r     <= we_r;
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Response registers: the valid pulse covers the RESP cycle, data and error hold until the next one.
  always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      resp_valid_r <= '0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      if (state_nxt_s == RESP) begin
        resp_valid_r <= req_onehot(accept_s ? pick_idx_s : grant_r);
      end else begin
        resp_valid_r <= '0;
      end
      if (accept_s && core_bad_s) begin
        resp_rdata_r <= 32'd0;
        resp_err_r   <= 1'b1;
      end else if (done_ok_s) begin
        resp_rdata_r <= we_r ? 32'd0 : ack_data_s;
        resp_err_r   <= 1'b0;
      end else if (done_err_s) begin
        resp_rdata_r <= 32'd0;
        resp_err_r   <= 1'b1;
      end else begin
        resp_rdata_r <= resp_rdata_r;
        resp_err_r   <= resp_err_r;
      end
    end
  end

  // SPR bus drive: only the latched core sees a nonzero value, and only while in ACCESS.
  always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      cpu_stb_r  <= '0;
      cpu_we_r   <= '0;
      cpu_addr_r <= '0;
      cpu_data_r <= '0;
    end else if (accept_s && !core_bad_s) begin
      for (int c = 0; c < NB_CORES; c++) begin
        cpu_stb_r[c]  <= core_oh_s[c];
        cpu_we_r[c]   <= core_oh_s[c] & sel_we_s;
        cpu_addr_r[c] <= core_oh_s[c] ? sel_addr_s : 16'd0;
        cpu_data_r[c] <= core_oh_s[c] ? sel_wdata_s : 32'd0;
      end
    end else if (done_ok_s || done_err_s) begin
      cpu_stb_r  <= '0;
      cpu_we_r   <= '0;
      cpu_addr_r <= '0;
      cpu_data_r <= '0;
    end else begin
      cpu_stb_r  <= cpu_stb_r;
      cpu_we_r   <= cpu_we_r;
      cpu_addr_r <= cpu_addr_r;
      cpu_data_r <= cpu_data_r;
    end
  end

  assign resp_valid_o = resp_valid_r;
  assign resp_rdata_o = resp_rdata_r;
  assign resp_err_o   = resp_err_r;
  assign cpu_stb_o    = cpu_stb_r;
  assign cpu_we_o     = cpu_we_r;
  assign cpu_addr_o   = cpu_addr_r;
  assign cpu_data_o   = cpu_data_r;

  adbg_spr_arbiter_chk #(
    .NB_REQ         (NB_REQ),
    .NB_CORES       (NB_CORES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_chk (
    .cpu_clk_i    (cpu_clk_i),
    .trstn_i      (trstn_i),
    .req_ready_o  (req_ready_o),
    .resp_valid_o (resp_valid_o),
    .cpu_stb_o    (cpu_stb_o)
  );

endmodule

// Protocol checker: one-hot handshakes and a single active strobe.
module adbg_spr_arbiter_chk #(
  parameter int NB_REQ         = 2,
  parameter int NB_CORES       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                cpu_clk_i,
  input logic                trstn_i,
  input logic [NB_REQ-1:0]   req_ready_o,
  input logic [NB_REQ-1:0]   resp_valid_o,
  input logic [NB_CORES-1:0] cpu_stb_o
);

  a_cfg_timeout: assert property (@(posedge cpu_clk_i) TIMEOUT_CYCLES >= 1);
  a_ready_oh: assert property (@(posedge cpu_clk_i) disable iff (!trstn_i) $onehot0(req_ready_o));
  a_resp_oh: assert property (@(posedge cpu_clk_i) disable iff (!trstn_i) $onehot0(resp_valid_o));
  a_stb_oh: assert property (@(posedge cpu_clk_i) disable iff (!trstn_i) $onehot0(cpu_stb_o));

endmodule

// File: doc/adbg_spr_arbiter.md
# adbg_spr_arbiter

Arbitrates OR1K SPR debug-bus accesses from several debug requesters (e.g. the JTAG debug BIU and a memory-mapped debug port) onto the per-core SPR bus array in the `cpu_clk_i` domain. Requesters are served one at a time in round-robin order. Each grant is held until the selected core acks, the target core is invalid, or an optional timeout expires. A one-cycle response with read data and an error flag is returned to the winning requester.

## Interface
- `NB_REQ`, 2: number of requesters.
- `NB_CORES`, 4: number of cores on the SPR bus array.
- `TIMEOUT_CYCLES`, 255: maximum strobe cycles before an error response (timeout build only); legal range ≥1.
- `cpu_clk_i` in 1: clock; all logic is in this domain.
- `trstn_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in [NB_REQ]: request pending.
- `req_ready_o` out [NB_REQ]: request accepted this cycle, one-hot or zero.
- `req_core_i` in [NB_REQ][3:0]: target core.
- `req_addr_i` in [NB_REQ][15:0]: SPR address.
- `req_wdata_i` in [NB_REQ][31:0]: write data.
- `req_we_i` in [NB_REQ]: 1 = write, 0 = read.
- `resp_valid_o` out [NB_REQ]: one-cycle response pulse, one-hot or zero; no backpressure.
- `resp_rdata_o` out 32: read data, shared by all requesters.
- `resp_err_o` out 1: error flag, qualified by `resp_valid_o`.
- `cpu_addr_o` out [NB_CORES][15:0], `cpu_data_o` out [NB_CORES][31:0], `cpu_we_o` out [NB_CORES], `cpu_stb_o` out [NB_CORES]: SPR bus drive.
- `cpu_data_i` in [NB_CORES][31:0], `cpu_ack_i` in [NB_CORES]: SPR bus return.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any `req_valid_i` is high, pick the first valid requester searching upward from `rr_ptr`, wrapping at NB_REQ.
  - Assert its `req_ready_o` combinationally.
  - Latch core, addr, wdata, we and grant index.
  - Go to ACCESS. If the core is ≥ NB_CORES, go to RESP with the error flag set instead.
- ACCESS:
  - Drive `cpu_stb_o`, `cpu_addr_o`, `cpu_data_o` and `cpu_we_o` of the latched core from registers.
  - All other cores see zero on every output.
  - On `cpu_ack_i` of the latched core: capture `cpu_data_i` if the access is a read (0 if a write), clear the error flag, go to RESP.
- RESP:
  - Pulse `resp_valid_o[grant]` for one cycle.
  - Set `rr_ptr` = (grant+1) mod NB_REQ.
  - Go to IDLE.
- `resp_rdata_o` and `resp_err_o` hold their values until the next RESP. `resp_rdata_o` = 0 on write or error responses.
- Acks from unselected cores, or acks outside ACCESS, are ignored.
- A requester may keep `req_valid_i` high after acceptance; it is treated as a new request at the next IDLE.
- Request inputs are sampled only in the acceptance cycle.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, all outputs 0 (`req_ready_o`, `resp_valid_o`, `resp_rdata_o`, `resp_err_o`, all cpu_* outputs).
- Accept in cycle N, ACCESS in N+1 (`cpu_stb_o` high), ack in N+1, RESP in N+2, IDLE in N+3.
- Minimum accept-to-response latency: 2 cycles. Maximum throughput with single-cycle acks: one access per 3 cycles.
- Invalid core: accept in N, response with err=1 in N+1; `cpu_stb_o` is never asserted.
- `cpu_stb_o` drops the cycle after the ack.
- Simultaneous requests: after reset, the lowest index wins; afterwards, strict rotation.
- Reset asserted mid-ACCESS: `cpu_stb_o` drops immediately and asynchronously. No response is issued. The requester must reissue.

## Configuration
- `ADBG_SPR_TIMEOUT_EN` defined:
  - A cycle counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS.
  - If there is no ack on the TIMEOUT_CYCLES-th strobe cycle, go to RESP with err=1 and rdata=0, so the strobe is high for exactly TIMEOUT_CYCLES cycles.
  - An ack on that final cycle wins and produces a normal response.
- Not defined: no counter; ACCESS waits indefinitely for an ack. `resp_err_o` is set only for an invalid core.

## Test plan
- Requester 0 reads core 1 at addr 0x3010; core 1 acks in its first strobe cycle with 0xDEADBEEF -> `cpu_stb_o[1]` high for 1 cycle; `resp_valid_o[0]` in N+2 with rdata 0xDEADBEEF, err 0; other cores' strobes stay 0.
- Requesters 0 and 1 request simultaneously and continuously -> grants in order 0,1,0,1; each `resp_valid_o` pulse goes to the matching requester.
- Requester 1 writes 0x12345678 to core 4 with NB_CORES=4 -> no strobe; `resp_valid_o[1]` in N+1 with err 1, rdata 0.
- Timeout build with TIMEOUT_CYCLES=16, no ack -> strobe high for exactly 16 cycles, then err 1. Ack on the 16th cycle -> err 0 with the acked data.
- Non-timeout build, ack after 40 cycles -> strobe held 40 cycles, normal response.
- Assert `trstn_i` during ACCESS -> strobe goes 0 immediately, no `resp_valid_o` pulse, `rr_ptr` returns to 0, and requester 0 wins the next contention.
